// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Port widths must never collapse to zero, even for tiny configurations.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int onehot_to_bin(input logic [31:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) r = r | i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr_i, optionally skipping mask_idx_i.
module rr_pick
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 5,
   parameter int IDW     = 3
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   input  logic               mask_en_i,
   input  logic [IDW-1:0]     mask_idx_i,
   output logic               found_o,
   output logic [IDW-1:0]     idx_o,
   output logic [NUM_REQ-1:0] onehot_o
);

   // Walk channels in priority order; the modulo wrap handles non-power-of-2 sizes.
   always_comb begin
      int c;
      found_o  = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      c        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(ptr_i) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!found_o && req_i[c] && !(mask_en_i && (c == int'(mask_idx_i)))) begin
            found_o     = 1'b1;
            idx_o       = IDW'(c);
            onehot_o[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-input round-robin arbiter with grant hold and zero-bubble handoff.
// Define ARB_HOLD_LIMIT_EN to add the hold_cnt port and forced rotation after HOLD_MAX cycles.
module rr_arbiter_n
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = 5,
   parameter int HOLD_MAX = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req,
   output logic [NUM_REQ-1:0]                   gnt,
   output logic                                 gnt_valid,
   output logic [clog2_min1(NUM_REQ)-1:0]       gnt_id
`ifdef ARB_HOLD_LIMIT_EN
   ,
   output logic [clog2_min1(HOLD_MAX+1)-1:0]    hold_cnt
`endif
);

   localparam int IDW = clog2_min1(NUM_REQ);

   arb_state_t         state_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     gntId_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [IDW-1:0]     pickIdx;
   logic [IDW-1:0]     ptr_d;
   logic [NUM_REQ-1:0] pickOnehot;
   logic               pickFound;
   logic               holderReq;
   logic               keepHolder;

   // While busy the holder is excluded, so the pick is always "the next one after the holder".
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req_i      (req),
      .ptr_i      (ptr_q),
      .mask_en_i  (state_q == ARB_BUSY),
      .mask_idx_i (gntId_q),
      .found_o    (pickFound),
      .idx_o      (pickIdx),
      .onehot_o   (pickOnehot)
   );

   assign holderReq = |(req & gnt_q);
   assign ptr_d     = (pickIdx == IDW'(NUM_REQ - 1)) ? '0 : pickIdx + IDW'(1);

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HCW = clog2_min1(HOLD_MAX + 1);

   logic [HCW-1:0] holdCnt_q;

   assign keepHolder = holderReq && !((holdCnt_q == HCW'(HOLD_MAX)) && pickFound);
   assign hold_cnt   = holdCnt_q;
`else
   assign keepHolder = holderReq;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ARB_IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         gntId_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         holdCnt_q <= '0;
`endif
      end else if (keepHolder) begin
`ifdef ARB_HOLD_LIMIT_EN
         if (holdCnt_q != HCW'(HOLD_MAX)) holdCnt_q <= holdCnt_q + HCW'(1);
`endif
      end else if (pickFound) begin
         state_q   <= ARB_BUSY;
         gnt_q     <= pickOnehot;
         gntId_q   <= pickIdx;
         ptr_q     <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
         holdCnt_q <= HCW'(1);
`endif
      end else begin
         state_q   <= ARB_IDLE;
         gnt_q     <= '0;
         gntId_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         holdCnt_q <= '0;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == ARB_BUSY);
   assign gnt_id    = gntId_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: directed scenarios then random request streams.
module tb_rr_arbiter_n;
   import arb_pkg::*;

   localparam int N   = 5;
   localparam int HM  = 4;
   localparam int IDW = clog2_min1(N);
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   typedef struct {
      logic [N-1:0] gnt;
      logic         valid;
      int           id;
      int           hcnt;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
`ifdef ARB_HOLD_LIMIT_EN
   logic [clog2_min1(HM+1)-1:0] hold_cnt;
`endif

   exp_t expQ[$];
   int   nChecks = 0;
   int   nErrors = 0;
   int   mHolder = -1;
   int   mPtr    = 0;
   int   mHcnt   = 0;

   always #5 clk = ~clk;

   rr_arbiter_n #(
      .NUM_REQ  (N),
      .HOLD_MAX (HM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
`ifdef ARB_HOLD_LIMIT_EN
      .gnt_id    (gnt_id),
      .hold_cnt  (hold_cnt)
`else
      .gnt_id    (gnt_id)
`endif
   );

   // Reference: who holds the link, where the round-robin pointer sits, how long the holder has had it.
   task automatic modelStep(input logic r, input logic [N-1:0] rq);
      bit others;
      int j;
      if (!r) begin
         mHolder = -1;
         mPtr    = 0;
         mHcnt   = 0;
         return;
      end
      others = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i] && i != mHolder) others = 1'b1;
      if (mHolder >= 0 && rq[mHolder] && !(LIMIT && mHcnt == HM && others)) begin
         if (mHcnt < HM) mHcnt++;
      end else begin
         j = -1;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (mPtr + k) % N;
            if (j < 0 && rq[c] && c != mHolder) j = c;
         end
         if (j >= 0) begin
            mHolder = j;
            mPtr    = (j + 1) % N;
            mHcnt   = 1;
         end else begin
            mHolder = -1;
            mHcnt   = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                input bit useLit, input logic [N-1:0] lit);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = rq;
      modelStep(r, rq);
      e.gnt   = (mHolder < 0) ? '0 : (N'(1) << mHolder);
      e.valid = (mHolder >= 0);
      e.id    = (mHolder < 0) ? 0 : mHolder;
      e.hcnt  = mHcnt;
      if (useLit) begin
         e.gnt   = lit;
         e.valid = |lit;
         e.id    = onehot_to_bin(32'(lit));
      end
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      nChecks++;
      if (gnt !== e.gnt) begin
         nErrors++;
         $display("[TB] FAIL gnt: got %b expected %b at %0t", gnt, e.gnt, $time);
      end
      nChecks++;
      if (gnt_valid !== e.valid) begin
         nErrors++;
         $display("[TB] FAIL gnt_valid: got %b expected %b at %0t", gnt_valid, e.valid, $time);
      end
      nChecks++;
      if (int'(gnt_id) != e.id || $isunknown(gnt_id)) begin
         nErrors++;
         $display("[TB] FAIL gnt_id: got %0d expected %0d at %0t", gnt_id, e.id, $time);
      end
`ifdef ARB_HOLD_LIMIT_EN
      nChecks++;
      if (int'(hold_cnt) != e.hcnt || $isunknown(hold_cnt)) begin
         nErrors++;
         $display("[TB] FAIL hold_cnt: got %0d expected %0d at %0t", hold_cnt, e.hcnt, $time);
      end
`endif
   endtask

   // Monitor: pops one expectation per edge and checks the structural invariants alongside.
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] prevGnt;
      int           waitCnt[N];
      bit           handoff;
      prevGnt = '0;
      for (int i = 0; i < N; i++) waitCnt[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
            nChecks++;
            if ($countones(gnt) > 1 || int'(gnt_id) != onehot_to_bin(32'(gnt))
                || gnt_valid !== (|gnt)) begin
               nErrors++;
               $display("[TB] FAIL consistency: gnt %b gnt_id %0d gnt_valid %b", gnt, gnt_id, gnt_valid);
            end
            handoff = (gnt != prevGnt) && (gnt != '0);
            for (int i = 0; i < N; i++) begin
               if (!rst || !req[i] || gnt[i]) begin
                  waitCnt[i] = 0;
               end else if (handoff) begin
                  waitCnt[i]++;
                  nChecks++;
                  if (waitCnt[i] > N) begin
                     nErrors++;
                     $display("[TB] FAIL starvation ch%0d: waited %0d handoffs, limit %0d", i, waitCnt[i], N);
                  end
               end
            end
            prevGnt = gnt;
         end
      end
   end

   initial begin : stimulus
      logic [N-1:0] rq;
      // Reset dominates requests, then lowest channel wins from ptr 0.
      applyStimulus(1'b0, 5'b11111, 1'b1, 5'b00000);
      applyStimulus(1'b0, 5'b11111, 1'b1, 5'b00000);
      applyStimulus(1'b1, 5'b11111, 1'b1, 5'b00001);
      applyStimulus(1'b0, 5'b00000, 1'b1, 5'b00000);
      // Simultaneous requests and bubble-free handoffs.
      applyStimulus(1'b1, 5'b10110, 1'b1, 5'b00010);
      applyStimulus(1'b1, 5'b10110, 1'b1, 5'b00010);
      applyStimulus(1'b1, 5'b10100, 1'b1, 5'b00100);
      applyStimulus(1'b1, 5'b10000, 1'b1, 5'b10000);
      applyStimulus(1'b1, 5'b00000, 1'b1, 5'b00000);
      // Wrap: after a grant to ch3 the pointer is 4, so ch0 beats ch3.
      applyStimulus(1'b1, 5'b01000, 1'b1, 5'b01000);
      applyStimulus(1'b1, 5'b00000, 1'b1, 5'b00000);
      applyStimulus(1'b1, 5'b01001, 1'b1, 5'b00001);
      applyStimulus(1'b1, 5'b01000, 1'b1, 5'b01000);
      applyStimulus(1'b1, 5'b00000, 1'b1, 5'b00000);
      // Mid-grant reset returns the pointer to 0.
      applyStimulus(1'b1, 5'b00100, 1'b1, 5'b00100);
      applyStimulus(1'b0, 5'b00100, 1'b1, 5'b00000);
      applyStimulus(1'b1, 5'b00110, 1'b1, 5'b00010);
      applyStimulus(1'b1, 5'b00000, 1'b1, 5'b00000);
      // Two contenders: alternate every HM cycles with the limit, otherwise ch0 keeps the link.
      for (int c = 0; c < 10; c++) begin
         if (LIMIT) applyStimulus(1'b1, 5'b00011, 1'b1, (((c / HM) % 2) != 0) ? 5'b00010 : 5'b00001);
         else       applyStimulus(1'b1, 5'b00011, 1'b1, 5'b00001);
      end
      for (int c = 0; c < 6; c++) applyStimulus(1'b1, 5'b00001, 1'b1, 5'b00001);
      applyStimulus(1'b1, 5'b00000, 1'b1, 5'b00000);
      // Random streams: bits toggle with low probability so grants are actually held.
      rq = '0;
      for (int c = 0; c < 4000; c++) begin
         rq = rq ^ (N'($urandom) & N'($urandom) & N'($urandom));
         applyStimulus(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, rq, 1'b0, '0);
      end
      applyStimulus(1'b1, 5'b00000, 1'b0, '0);
      for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
      #3;
      nChecks++;
      if (expQ.size() != 0) begin
         nErrors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
